// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with clear-on-init sequence and per-register pending scoreboard
// Optional same-cycle write-to-read forwarding enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   a1,
    input  logic [AW-1:0]   a2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we3,
    input  logic [AW-1:0]   a3,
    input  logic [XLEN-1:0] wd3,
    input  logic            rsv_valid,
    input  logic [AW-1:0]   rsv_addr,
    output logic            busy1,
    output logic            busy2,
    output logic            init_done
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            state;
    logic [AW-1:0]     clr_cnt;
    logic [XLEN-1:0]   regs [NREGS];
    logic [NREGS-1:0]  pending;
    logic [NREGS-1:0]  pending_nxt;
    logic              run;
    logic              wr_hit;

    assign run    = (state == S_RUN);
    assign wr_hit = run && we3 && (a3 != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_INIT;
            clr_cnt   <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    clr_cnt <= clr_cnt + AW'(1);
                    if (clr_cnt == AW'(NREGS - 1)) begin
                        state     <= S_RUN;
                        init_done <= 1'b1;
                    end
                end
                S_RUN: begin
                    state <= S_RUN;
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

    // Reservation is applied after the write-clear so a same-cycle new producer keeps the bit set.
    always_comb begin
        pending_nxt = pending;
        if (we3) begin
            pending_nxt[a3] = 1'b0;
        end
        if (rsv_valid) begin
            pending_nxt[rsv_addr] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (run) begin
            pending <= pending_nxt;
        end
    end

    // Storage has no reset: contents are only zeroed by the INIT sweep.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == S_INIT) begin
                regs[clr_cnt] <= '0;
            end else if (wr_hit) begin
                regs[a3] <= wd3;
            end
        end
    end

    always_comb begin
        rd1   = '0;
        busy1 = 1'b0;
        if (run && (a1 != '0)) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_hit && (a3 == a1)) begin
                rd1   = wd3;
                busy1 = rsv_valid && (rsv_addr == a1);
            end else begin
                rd1   = regs[a1];
                busy1 = pending[a1];
            end
`else
            rd1   = regs[a1];
            busy1 = pending[a1];
`endif
        end
    end

    always_comb begin
        rd2   = '0;
        busy2 = 1'b0;
        if (run && (a2 != '0)) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_hit && (a3 == a2)) begin
                rd2   = wd3;
                busy2 = rsv_valid && (rsv_addr == a2);
            end else begin
                rd2   = regs[a2];
                busy2 = pending[a2];
            end
`else
            rd2   = regs[a2];
            busy2 = pending[a2];
`endif
        end
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, the data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, the register count (power of two, at least 2).
REQ-003 SHALL have parameter AW, default $clog2(NREGS), the address width.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port a1  input  AW  read port 1 address.
REQ-007 SHALL have port a2  input  AW  read port 2 address.
REQ-008 SHALL have port rd1  output  XLEN  read port 1 data.
REQ-009 SHALL have port rd2  output  XLEN  read port 2 data.
REQ-010 SHALL have port we3  input  1  write enable.
REQ-011 SHALL have port a3  input  AW  write address.
REQ-012 SHALL have port wd3  input  XLEN  write data.
REQ-013 SHALL have port rsv_valid  input  1  scoreboard reserve request.
REQ-014 SHALL have port rsv_addr  input  AW  register to mark pending.
REQ-015 SHALL have port busy1  output  1  the register at a1 is pending.
REQ-016 SHALL have port busy2  output  1  the register at a2 is pending.
REQ-017 SHALL have port init_done  output  1  the clear sequence is complete and the file is usable.

Function
REQ-018 SHALL implement a two-state FSM: INIT and RUN.
REQ-019 In INIT, a clear counter SHALL zero one register per cycle, from index 0 to NREGS-1, then go to RUN on the next edge; INIT lasts exactly NREGS cycles.
REQ-020 In INIT: init_done=0; rd1, rd2, busy1 and busy2 SHALL be 0; we3 and rsv_valid SHALL be ignored.
REQ-021 In RUN: init_done=1; a write with we3=1 and a3!=0 SHALL update reg[a3] at the rising edge.
REQ-022 Reads SHALL be combinational: rd1=reg[a1], rd2=reg[a2]; address 0 SHALL always read 0.
REQ-023 Writes and reservations to address 0 SHALL be discarded; pending[0] SHALL stay 0.
REQ-024 rsv_valid=1 in RUN SHALL set pending[rsv_addr] at the edge.
REQ-025 we3=1 in RUN SHALL clear pending[a3] at the edge.
REQ-026 If rsv_valid and we3 target the same address in the same cycle: the data SHALL be written and pending SHALL end set (the new producer wins).
REQ-027 busy1=pending[a1] and busy2=pending[a2], both combinational.
REQ-028 Both read ports SHALL work independently, including a1==a2.

Reset
REQ-029 rst_n=0 at an edge SHALL force INIT, clear counter=0, all pending bits=0 and init_done=0.
REQ-030 Register contents SHALL be cleared only by the INIT sequence, never by a single-cycle reset.
REQ-031 A reset asserted mid-INIT or mid-RUN SHALL restart the full INIT sequence.

Configuration
REQ-032 Macro REGFILE_BYPASS_EN, when defined in RUN with we3=1, a3!=0 and a3==a1 (or a2): rd1 (rd2) SHALL return wd3 in the same cycle, and busy1 (busy2) SHALL be 0 unless rsv_valid also targets that address.
REQ-033 Without REGFILE_BYPASS_EN: a read in the write cycle SHALL return the old value, and busy SHALL reflect pending before the edge.

Verification
REQ-034 Reset, then count cycles: init_done rises exactly NREGS=32 cycles after rst_n deasserts; every read returns 0.
REQ-035 Write 0x12345678 to x10, then read a1=10, a2=0: rd1=0x12345678, rd2=0.
REQ-036 Reserve x5, then read a1=5: busy1=1. Write 0xCAFEF00D to x5: busy1=0 after the edge and rd1=0xCAFEF00D.
REQ-037 In the same cycle, rsv_valid and we3 to x7 with 0xA5A5A5A5: after the edge rd=0xA5A5A5A5 and busy=1. Write and reservation to x0: rd=0, busy=0.
REQ-038 Write 0x1 to x3 with a1=3 in the same cycle: rd1=0x1 with REGFILE_BYPASS_EN defined, the old value without it.
REQ-039 Write x4=0xFF, assert rst_n=0 mid-RUN: init_done=0, writes are ignored during INIT, and x4 reads 0 after init_done.
